// File: rtl/renode_ahb_pkg.sv
// Shared AHB-Lite encodings for the Renode bridge blocks.
// This package also holds the per-manager port state used by the two-manager arbiter.
package renode_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Pending = 2'd1,
        Data    = 2'd2
    } arbiter_port_state_e;

    localparam int unsigned NumManagers = 2;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are never queued.
    function automatic logic is_transfer(logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/renode_ahb_arbiter_port.sv
// Per-manager input stage: captures an address phase into a hold register,
// stalls the manager until the shared subordinate finishes its data phase.
module renode_ahb_arbiter_port
    import renode_ahb_pkg::*;
#(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
) (
    input  logic                    hclk_i,
    input  logic                    hreset_i,
    input  logic [1:0]              htrans_i,
    input  logic [AddressWidth-1:0] haddr_i,
    input  logic                    hwrite_i,
    input  logic [2:0]              hsize_i,
    input  logic                    grant_i,
    input  logic                    s_hreadyout_i,
    input  logic                    s_hresp_i,
    input  logic [DataWidth-1:0]    s_hrdata_i,
    output logic                    hready_o,
    output logic                    hresp_o,
    output logic [DataWidth-1:0]    hrdata_o,
    output logic                    pending_o,
    output logic                    data_o,
    output logic [AddressWidth-1:0] hold_addr_o,
    output logic                    hold_write_o,
    output logic [2:0]              hold_size_o
);

    arbiter_port_state_e     state_q;
    logic [AddressWidth-1:0] addr_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic                    capture;

    always_comb begin
        unique case (state_q)
            Pending: hready_o = 1'b0;
            Data:    hready_o = s_hreadyout_i;
            default: hready_o = 1'b1;
        endcase
    end

    assign capture = hready_o && is_transfer(htrans_i);

    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state_q <= Idle;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            if (capture) begin
                addr_q  <= haddr_i;
                write_q <= hwrite_i;
                size_q  <= hsize_i;
            end
            unique case (state_q)
                Idle:    if (capture) state_q <= Pending;
                Pending: if (grant_i) state_q <= Data;
                // Completion and a fresh capture can coincide: pipelined back-to-back.
                Data:    if (s_hreadyout_i) state_q <= capture ? Pending : Idle;
                default: state_q <= Idle;
            endcase
        end
    end

    assign data_o       = (state_q == Data);
    assign pending_o    = (state_q == Pending);
    assign hresp_o      = data_o ? s_hresp_i : HRESP_OKAY;
    assign hrdata_o     = data_o ? s_hrdata_i : '0;
    assign hold_addr_o  = addr_q;
    assign hold_write_o = write_q;
    assign hold_size_o  = size_q;

endmodule

// File: rtl/renode_ahb_arbiter.sv
// Two-manager AHB-Lite arbiter in front of a single subordinate port.
// Round-robin on ties; data-phase signals follow the current data-phase owner.
module renode_ahb_arbiter
    import renode_ahb_pkg::*;
#(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
) (
    input  logic                                 hclk,
    input  logic                                 hreset,
    input  logic [NumManagers-1:0][1:0]          m_htrans,
    input  logic [NumManagers-1:0][AddressWidth-1:0] m_haddr,
    input  logic [NumManagers-1:0]               m_hwrite,
    input  logic [NumManagers-1:0][2:0]          m_hsize,
    input  logic [NumManagers-1:0][DataWidth-1:0] m_hwdata,
    output logic [NumManagers-1:0]               m_hready,
    output logic [NumManagers-1:0]               m_hresp,
    output logic [NumManagers-1:0][DataWidth-1:0] m_hrdata,
    output logic [1:0]                           s_htrans,
    output logic [AddressWidth-1:0]              s_haddr,
    output logic                                 s_hwrite,
    output logic [2:0]                           s_hsize,
    output logic [DataWidth-1:0]                 s_hwdata,
    output logic                                 s_hready,
    output logic                                 s_hmaster,
    input  logic                                 s_hreadyout,
    input  logic                                 s_hresp,
    input  logic [DataWidth-1:0]                 s_hrdata
);

    logic [NumManagers-1:0]                   pending;
    logic [NumManagers-1:0]                   in_data;
    logic [NumManagers-1:0]                   grant;
    logic [NumManagers-1:0][AddressWidth-1:0] hold_addr;
    logic [NumManagers-1:0]                   hold_write;
    logic [NumManagers-1:0][2:0]              hold_size;
    logic                                     issue;
    logic                                     winner;
    logic                                     last_grant_q;

    for (genvar i = 0; i < NumManagers; i++) begin : g_port
        renode_ahb_arbiter_port #(
            .AddressWidth(AddressWidth),
            .DataWidth   (DataWidth)
        ) u_port (
            .hclk_i       (hclk),
            .hreset_i     (hreset),
            .htrans_i     (m_htrans[i]),
            .haddr_i      (m_haddr[i]),
            .hwrite_i     (m_hwrite[i]),
            .hsize_i      (m_hsize[i]),
            .grant_i      (grant[i]),
            .s_hreadyout_i(s_hreadyout),
            .s_hresp_i    (s_hresp),
            .s_hrdata_i   (s_hrdata),
            .hready_o     (m_hready[i]),
            .hresp_o      (m_hresp[i]),
            .hrdata_o     (m_hrdata[i]),
            .pending_o    (pending[i]),
            .data_o       (in_data[i]),
            .hold_addr_o  (hold_addr[i]),
            .hold_write_o (hold_write[i]),
            .hold_size_o  (hold_size[i])
        );
    end

    // A stalled data phase already means s_hreadyout is low, so ready alone gates issue.
    assign issue = (|pending) && s_hreadyout;

    always_comb begin
        if (&pending) winner = ~last_grant_q;
        else          winner = pending[1];
    end

    assign grant = issue ? (winner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge hclk) begin
        if (hreset)     last_grant_q <= 1'b1;
        else if (issue) last_grant_q <= winner;
    end

    always_comb begin
        s_htrans  = HTRANS_IDLE;
        s_haddr   = '0;
        s_hwrite  = 1'b0;
        s_hsize   = '0;
        s_hmaster = 1'b0;
        if (issue) begin
            s_htrans  = HTRANS_NONSEQ;
            s_haddr   = hold_addr[winner];
            s_hwrite  = hold_write[winner];
            s_hsize   = hold_size[winner];
            s_hmaster = winner;
        end
    end

    always_comb begin
        s_hwdata = '0;
        if (in_data[0])      s_hwdata = m_hwdata[0];
        else if (in_data[1]) s_hwdata = m_hwdata[1];
    end

    assign s_hready = s_hreadyout;

endmodule
